// File: rtl/status_capture_reg.sv
// Hardware-to-CPU status register: conditions up to 8 fabric status inputs, holds them
// transparent or sticky (clear-on-read), serves one-cycle CPU reads and a masked level irq.
module status_capture_reg #(
   parameter int         NumInputs  = 8,
   parameter bit         SyncInputs = 1'b1,
   parameter logic [7:0] StickyMask = 8'h00,
   parameter logic [7:0] IntMask    = 8'h00
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] status_in,
   input  logic       rd_req,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       int_en,
   output logic       irq,
   output logic [7:0] status_view
);

   function automatic logic [7:0] live_mask(input int n);
      logic [7:0] m;
      m = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   localparam logic [7:0] LiveMask = live_mask(NumInputs);

   logic [7:0] sync1_q, sync1_d;
   logic [7:0] sync2_q, sync2_d;
   logic [7:0] status_q, status_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;
   logic       irq_q, irq_d;
   logic [7:0] cond_s;
   logic [7:0] keep_s;

   // Next-state logic: conditioning, sticky/transparent update, read capture and irq.
   always_comb begin
      sync1_d = status_in & LiveMask;
      sync2_d = sync1_q;
      if (SyncInputs) begin
         cond_s = sync2_q & LiveMask;
      end else begin
         cond_s = status_in & LiveMask;
      end
      // A read clears sticky bits at the same edge it snapshots them; a new event still sets.
      keep_s   = status_q & ~{8{rd_req}};
      status_d = (cond_s & ~StickyMask) | ((cond_s | keep_s) & StickyMask);
      if (rd_req) begin
         rd_data_d = status_q;
      end else begin
         rd_data_d = rd_data_q;
      end
      rd_valid_d = rd_req;
      irq_d      = int_en & (|(status_q & IntMask & LiveMask));
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q    <= 8'h00;
         sync2_q    <= 8'h00;
         status_q   <= 8'h00;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         status_q   <= status_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         irq_q      <= irq_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign irq         = irq_q;
   assign status_view = status_q;

endmodule

// File: tb/tb_status_capture_reg.sv
// Directed bench for status_capture_reg: read snapshots go through an expected-value queue,
// checked when rd_valid appears; three instances cover sync/no-sync and a narrow NumInputs.
module tb_status_capture_reg;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] status_in = 8'hFF;
   logic       rd_req = 1'b0;
   logic       int_en = 1'b0;

   logic [7:0] rd_data_a, view_a, rd_data_b, view_b, rd_data_c, view_c;
   logic       valid_a, irq_a, valid_b, irq_b, valid_c, irq_c;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];

   always #5 clock = ~clock;

   status_capture_reg #(.NumInputs(8), .SyncInputs(1'b0), .StickyMask(8'h09), .IntMask(8'h04)) dut_a (
      .clock(clock), .reset(reset), .status_in(status_in), .rd_req(rd_req), .rd_data(rd_data_a),
      .rd_valid(valid_a), .int_en(int_en), .irq(irq_a), .status_view(view_a));

   status_capture_reg #(.NumInputs(2), .SyncInputs(1'b1), .StickyMask(8'h09), .IntMask(8'h04)) dut_b (
      .clock(clock), .reset(reset), .status_in(status_in), .rd_req(rd_req), .rd_data(rd_data_b),
      .rd_valid(valid_b), .int_en(int_en), .irq(irq_b), .status_view(view_b));

   status_capture_reg #(.NumInputs(8), .SyncInputs(1'b1), .StickyMask(8'h09), .IntMask(8'h04)) dut_c (
      .clock(clock), .reset(reset), .status_in(status_in), .rd_req(rd_req), .rd_data(rd_data_c),
      .rd_valid(valid_c), .int_en(int_en), .irq(irq_c), .status_view(view_c));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Scoreboard: every rd_valid cycle of dut_a consumes one expected snapshot.
   always @(negedge clock) begin
      if (valid_a === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("rd_valid_spurious", {7'd0, valid_a}, 8'h00);
         end else begin
            chk("rd_data", rd_data_a, exp_q.pop_front());
         end
      end
   end

   initial begin
      // Reset held with all inputs high
      step(2);
      chk("rst_rd_data", rd_data_a, 8'h00);
      chk("rst_rd_valid", {7'd0, valid_a}, 8'h00);
      chk("rst_irq", {7'd0, irq_a}, 8'h00);
      chk("rst_view_a", view_a, 8'h00);
      chk("rst_view_c", view_c, 8'h00);
      reset = 1'b1;
      status_in = 8'h00;
      step(3);

      // Transparent capture and first read
      status_in = 8'h5A;
      step(1);
      chk("t2_view", view_a, 8'h5A);
      step(1);
      rd_req = 1'b1;
      exp_q.push_back(8'h5A);
      step(1);
      rd_req = 1'b0;
      chk("t2_valid_hi", {7'd0, valid_a}, 8'h01);
      step(1);
      chk("t2_valid_lo", {7'd0, valid_a}, 8'h00);
      chk("t2_data_hold", rd_data_a, 8'h5A);
      status_in = 8'h00;
      step(1);
      chk("t2_sticky_held", view_a, 8'h08);
      rd_req = 1'b1;
      exp_q.push_back(8'h08);
      step(1);
      rd_req = 1'b0;
      chk("t2_sticky_cleared", view_a, 8'h00);
      step(1);

      // Sticky bit0 pulse, back-to-back reads
      status_in = 8'h01;
      step(1);
      status_in = 8'h00;
      step(1);
      chk("t3_view", view_a, 8'h01);
      rd_req = 1'b1;
      exp_q.push_back(8'h01);
      step(1);
      exp_q.push_back(8'h00);
      chk("t3_valid_1", {7'd0, valid_a}, 8'h01);
      step(1);
      rd_req = 1'b0;
      chk("t3_valid_2", {7'd0, valid_a}, 8'h01);
      step(1);
      chk("t3_valid_lo", {7'd0, valid_a}, 8'h00);

      // Set wins over clear on sticky bit3
      status_in = 8'h08;
      step(1);
      rd_req = 1'b1;
      exp_q.push_back(8'h08);
      step(1);
      rd_req = 1'b0;
      status_in = 8'h00;
      chk("t4_set_wins", view_a, 8'h08);
      step(1);
      rd_req = 1'b1;
      exp_q.push_back(8'h08);
      step(1);
      exp_q.push_back(8'h00);
      chk("t4_cleared", view_a, 8'h00);
      step(1);
      rd_req = 1'b0;
      step(1);

      // Unused bits stay zero
      status_in = 8'hFF;
      step(3);
      chk("unused_view_b", view_b, 8'h03);
      chk("sync_view_c", view_c, 8'hFF);
      status_in = 8'h00;
      step(3);
      rd_req = 1'b1;
      exp_q.push_back(8'h09);
      step(1);
      rd_req = 1'b0;
      step(1);

      // irq latency and int_en gating
      int_en = 1'b1;
      status_in = 8'h04;
      step(1);
      chk("t5_irq_a_e1", {7'd0, irq_a}, 8'h00);
      chk("t5_irq_c_e1", {7'd0, irq_c}, 8'h00);
      step(1);
      chk("t5_irq_a_e2", {7'd0, irq_a}, 8'h01);
      chk("t5_irq_c_e2", {7'd0, irq_c}, 8'h00);
      step(1);
      chk("t5_irq_c_e3", {7'd0, irq_c}, 8'h00);
      step(1);
      chk("t5_irq_c_e4", {7'd0, irq_c}, 8'h01);
      chk("t5_irq_b_never", {7'd0, irq_b}, 8'h00);
      chk("t5_view_b", view_b & 8'h04, 8'h00);
      int_en = 1'b0;
      step(1);
      chk("t5_irq_a_off", {7'd0, irq_a}, 8'h00);
      chk("t5_irq_c_off", {7'd0, irq_c}, 8'h00);
      chk("t5_view_kept", view_a, 8'h04);
      status_in = 8'h00;
      step(3);

      // Async reset in the cycle after a read
      status_in = 8'h09;
      step(1);
      status_in = 8'h00;
      step(1);
      chk("t6_view_pre", view_a, 8'h09);
      rd_req = 1'b1;
      exp_q.push_back(8'h09);
      status_in = 8'h08;
      step(1);
      rd_req = 1'b0;
      status_in = 8'h00;
      chk("t6_valid_pre", {7'd0, valid_a}, 8'h01);
      chk("t6_sticky_pre", view_a, 8'h08);
      reset = 1'b0;
      #1;
      chk("t6_valid_rst", {7'd0, valid_a}, 8'h00);
      chk("t6_view_rst", view_a, 8'h00);
      chk("t6_data_rst", rd_data_a, 8'h00);
      exp_q.delete();
      step(2);
      reset = 1'b1;
      step(2);
      chk("t6_view_after", view_a, 8'h00);
      chk("queue_drained", 8'(exp_q.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
